decrypt_byte: RTL and testbench
===============================

Name: decrypt_byte

Overview:
- Single-byte cipher decryption stage; the inverse of the team's byte encryptor.
- Encryptor: c = swap_nibbles(AES_SBOX(p)) ^ KEY.
- This block computes p = AES_INV_SBOX(swap_nibbles(c ^ KEY)) and registers the result.
- Sits on the datapath after the ciphertext source. It is a one-cycle pipelined, fully combinational-core transform with a valid qualifier.

Parameters:
- KEY, 8'h5A, whitening key XORed onto the ciphertext before un-permuting. Must equal the encryptor's KEY.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- din  input  8  ciphertext byte.
- din_valid  input  1  din is meaningful this cycle.
- dout  output  8  decrypted plaintext byte, registered.
- dout_valid  output  1  dout holds a result for a din accepted the previous cycle.

Behaviour:
- Combinational core, three steps:
  - step 1: x = din ^ KEY.
  - step 2: y = {x[3:0], x[7:4]} (nibble swap).
  - step 3: p = AES_INV_SBOX[y], the standard FIPS-197 inverse S-box, all 256 entries.
- Latency: exactly 1 clk. If din_valid=1 at edge N, then dout=p(din) and dout_valid=1 after edge N.
- If din_valid=0 at an edge:
  - dout_valid goes 0 after that edge.
  - dout holds its previous value; it is not updated.
- Back-to-back: din_valid may be high every cycle; throughput is 1 byte/clk. No stall or backpressure.
- Reset: while rst_n=0 at a rising edge, dout=8'h00 and dout_valid=0. Reset overrides a simultaneous din_valid=1.
- Reset mid-stream: the in-flight byte is discarded. The first valid output after reset corresponds to the first din_valid sampled with rst_n=1.
- The mapping is a bijection on 0x00..0xFF. No illegal inputs, no X propagation from the table, with a default branch covering all codes.
- Must be exact inverse of the encryptor for all 256 values.

Decomposition:
- Shared package decrypt_pkg holds:
  - localparam DEFAULT_KEY = 8'h5A.
  - Function swap_nibbles.
  - 256-entry AES_INV_SBOX constant/function, shared with the encryptor's AES_SBOX for round-trip checks.
- One sub-module is natural: inv_sbox_8 (purely combinational, 8-bit in, 8-bit out, case/table of 256 entries). The top level holds the XOR, the swap, and the output registers.

Test Plan:
- Each case below: drive din with din_valid=1; dout must equal the listed value and dout_valid=1 exactly one clk later.
  - 0x6C -> dout 0x00
  - 0x9D -> dout 0x01
  - 0x62 -> dout 0x41
  - 0x65 -> dout 0x7E
  - 0x3A -> dout 0xA5
  - 0x3B -> dout 0xFF
- Streaming: the six bytes above on consecutive cycles with din_valid held high -> the six results appear in order on consecutive cycles, no gaps.
- Exhaustive round trip: for p = 0x00..0xFF, drive din = swap_nibbles(AES_SBOX(p)) ^ 0x5A -> dout == p for all 256. Also confirm the outputs are all distinct.
- Reset: assert rst_n=0 for 2 cycles while driving din=0x3B, din_valid=1 -> dout=0x00 and dout_valid=0 throughout. After release, the next edge with din=0x3B gives dout=0xFF.
- Valid gap: din=0x6C valid, then din_valid=0 with din=0x9D -> dout_valid drops to 0 and dout stays 0x00.
- KEY override: KEY=8'h00, din=0x36 -> dout 0x00. Swap gives 0x63, inverse S-box gives 0x00.

Source files
------------

// File: rtl/decrypt_pkg.sv
// Shared definitions for the byte cipher: whitening key, nibble swap and the
// FIPS-197 forward/inverse S-box tables used by the encryptor and decryptor.
package decrypt_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t DEFAULT_KEY = 8'h5A;

  localparam byte_t AES_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t AES_INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic byte_t swap_nibbles(input byte_t b);
    return {b[3:0], b[7:4]};
  endfunction

  // Forward direction, used by the encryptor and by round-trip checks.
  function automatic byte_t encrypt(input byte_t p, input byte_t key);
    return swap_nibbles(AES_SBOX[p]) ^ key;
  endfunction

endpackage

// File: rtl/decrypt_byte_if.sv
// Ciphertext-in / plaintext-out byte stream with valid qualifiers.
interface decrypt_byte_if;
  import decrypt_pkg::*;

  byte_t din;
  logic  din_valid;
  byte_t dout;
  logic  dout_valid;

  modport master (output din, output din_valid, input dout, input dout_valid);
  modport slave  (input din, input din_valid, output dout, output dout_valid);
endinterface

// File: rtl/inv_sbox_8.sv
// Purely combinational FIPS-197 inverse S-box lookup.
module inv_sbox_8
  import decrypt_pkg::*;
(
  input  byte_t sin,
  output byte_t sout
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sout = 8'h00;
    sout = AES_INV_SBOX[sin];
  end

endmodule

// File: rtl/decrypt_byte.sv
// Single-byte decryption stage: un-whiten, nibble swap, inverse S-box, then
// one register stage with a valid qualifier.
module decrypt_byte
  import decrypt_pkg::*;
#(
  parameter byte_t KEY = DEFAULT_KEY
) (
  input  logic           clk,
  input  logic           rst_n,
  decrypt_byte_if.slave  bus
);

  byte_t unpermuted;
  byte_t plain;
  byte_t dout_q;
  logic  dout_valid_q;

  assign unpermuted = swap_nibbles(bus.din ^ KEY);

  inv_sbox_8 u_inv_sbox (
    .sin  (unpermuted),
    .sout (plain)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= bus.din_valid;
      // dout keeps the last plaintext across idle cycles.
      if (bus.din_valid) dout_q <= plain;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_decrypt_byte.sv
// Self-checking bench for decrypt_byte; reference built from GF(2^8) S-box math.
module tb_decrypt_byte;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decrypt_byte_if bus_a ();
  decrypt_byte_if bus_k0 ();

  decrypt_byte u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  decrypt_byte #(.KEY(8'h00)) u_dut_k0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_k0)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_ref [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w = {b, b};
    w = w >> (8 - n);
    return w[7:0];
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] p);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, p);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] swap(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] key);
    return swap(sbox_ref[p]) ^ key;
  endfunction

  // Plaintext is whatever byte encrypts to c under key.
  function automatic logic [7:0] ref_dec(input logic [7:0] c, input logic [7:0] key);
    for (int p = 0; p < 256; p++)
      if (enc(8'(p), key) == c) return 8'(p);
    return 8'h00;
  endfunction

  task automatic cycle_a(input logic [7:0] d, input logic v);
    bus_a.din = d;
    bus_a.din_valid = v;
    @(negedge clk);
  endtask

  logic [7:0] vec_din [6] = '{8'h6C, 8'h9D, 8'h62, 8'h65, 8'h3A, 8'h3B};
  logic [7:0] vec_exp [6] = '{8'h00, 8'h01, 8'h41, 8'h7E, 8'hA5, 8'hFF};

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle_a(8'h3B, 1'b1);
      checks++;
      if (bus_a.dout !== 8'h00 || bus_a.dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] got dout=%h v=%b want 00/0", i, bus_a.dout, bus_a.dout_valid);
      end
    end
    rst_n = 1'b1;
    cycle_a(8'h3B, 1'b1);
    checks++;
    if (bus_a.dout !== 8'hFF || bus_a.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got dout=%h v=%b want ff/1", bus_a.dout, bus_a.dout_valid);
    end
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 6; i++) begin
      cycle_a(vec_din[i], 1'b1);
      checks++;
      if (bus_a.dout !== vec_exp[i] || bus_a.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL vector din=%h got dout=%h v=%b want %h/1", vec_din[i], bus_a.dout,
                 bus_a.dout_valid, vec_exp[i]);
      end
      cycle_a(8'h00, 1'b0);
      checks++;
      if (bus_a.dout !== vec_exp[i] || bus_a.dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL vector_hold din=%h got dout=%h v=%b want %h/0", vec_din[i], bus_a.dout,
                 bus_a.dout_valid, vec_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      cycle_a(vec_din[i], 1'b1);
      checks++;
      if (bus_a.dout !== vec_exp[i] || bus_a.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d] got dout=%h v=%b want %h/1", i, bus_a.dout, bus_a.dout_valid,
                 vec_exp[i]);
      end
    end
    cycle_a(8'h00, 1'b0);
  endtask

  task automatic test_valid_gap();
    cycle_a(8'h6C, 1'b1);
    checks++;
    if (bus_a.dout !== 8'h00 || bus_a.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_first got dout=%h v=%b want 00/1", bus_a.dout, bus_a.dout_valid);
    end
    cycle_a(8'h9D, 1'b0);
    checks++;
    if (bus_a.dout !== 8'h00 || bus_a.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_idle got dout=%h v=%b want 00/0", bus_a.dout, bus_a.dout_valid);
    end
  endtask

  task automatic test_round_trip();
    logic [255:0] seen = '0;
    int distinct = 0;
    for (int p = 0; p < 256; p++) begin
      cycle_a(enc(8'(p), 8'h5A), 1'b1);
      checks++;
      if (bus_a.dout !== 8'(p) || bus_a.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL round_trip p=%h got dout=%h v=%b", p[7:0], bus_a.dout, bus_a.dout_valid);
      end
      if (!seen[bus_a.dout]) distinct++;
      seen[bus_a.dout] = 1'b1;
    end
    checks++;
    if (distinct !== 256) begin
      errors++;
      $display("FAIL distinct got %0d want 256", distinct);
    end
    cycle_a(8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] exp_d = 8'hFF;
    logic [7:0] d;
    logic v;
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      v = ($urandom_range(0, 3) != 0);
      cycle_a(d, v);
      if (v) exp_d = ref_dec(d, 8'h5A);
      checks++;
      if (bus_a.dout !== exp_d || bus_a.dout_valid !== v) begin
        errors++;
        $display("FAIL random[%0d] din=%h vin=%b got dout=%h v=%b want %h/%b", i, d, v,
                 bus_a.dout, bus_a.dout_valid, exp_d, v);
      end
    end
  endtask

  task automatic test_reset_midstream();
    cycle_a(8'h62, 1'b1);
    rst_n = 1'b0;
    cycle_a(8'h65, 1'b1);
    checks++;
    if (bus_a.dout !== 8'h00 || bus_a.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got dout=%h v=%b want 00/0", bus_a.dout, bus_a.dout_valid);
    end
    rst_n = 1'b1;
    cycle_a(8'h3A, 1'b0);
    checks++;
    if (bus_a.dout !== 8'h00 || bus_a.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle got dout=%h v=%b want 00/0", bus_a.dout, bus_a.dout_valid);
    end
    cycle_a(8'h3A, 1'b1);
    checks++;
    if (bus_a.dout !== 8'hA5 || bus_a.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_first got dout=%h v=%b want a5/1", bus_a.dout, bus_a.dout_valid);
    end
    cycle_a(8'h00, 1'b0);
  endtask

  task automatic test_key_override();
    logic [7:0] d;
    bus_k0.din = 8'h36;
    bus_k0.din_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_k0.dout !== 8'h00 || bus_k0.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL key0 got dout=%h v=%b want 00/1", bus_k0.dout, bus_k0.dout_valid);
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      bus_k0.din = d;
      @(negedge clk);
      checks++;
      if (bus_k0.dout !== ref_dec(d, 8'h00)) begin
        errors++;
        $display("FAIL key0_random din=%h got %h want %h", d, bus_k0.dout, ref_dec(d, 8'h00));
      end
    end
    bus_k0.din_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.din = 8'h00;
    bus_a.din_valid = 1'b0;
    bus_k0.din = 8'h00;
    bus_k0.din_valid = 1'b0;
    for (int p = 0; p < 256; p++) sbox_ref[p] = sbox_math(8'(p));
    @(negedge clk);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_valid_gap();
    test_round_trip();
    test_random();
    test_reset_midstream();
    test_key_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
